// File: rtl/blk_9ca83e_pkg.sv
// Shared definitions for the output_mmap m_axi read-port arbiter: R-channel last-bit
// positions, arbiter FSM states and the round-robin pointer advance.
package output_drainer_q_fp32_output_mmap_m_axi_pkg;

    localparam int RLAST_BURST = 1;
    localparam int RLAST_REQ   = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Next round-robin start position after serving requester cur out of n.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return ((cur + 1) >= n) ? 0 : (cur + 1);
    endfunction

endpackage

// File: rtl/blk_9ca83e_fifo.sv
// Small show-ahead FIFO holding the requester ID of every issued-but-incomplete read.
// The head entry is visible combinationally so returning beats can be routed with no latency.
module output_drainer_q_fp32_output_mmap_m_axi_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/blk_9ca83e.sv
// Round-robin arbiter sharing one HLS read port of the output_mmap m_axi adapter between
// NUM_REQ requesters; returned beats are routed back in issue order via a grant-ID FIFO.
module blk_9ca83e
    import output_drainer_q_fp32_output_mmap_m_axi_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_OUTSTANDING = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_REQ*32-1:0]         s_arlen,
    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rlast,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [31:0]                   m_arlen,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          m_rburst_ready
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e            r_state;
    arb_state_e            w_state_next;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [31:0]           r_arlen;
    logic                  r_rburst_ready;

    logic [ADDR_WIDTH-1:0] w_req_addr [NUM_REQ];
    logic [31:0]           w_req_len  [NUM_REQ];
    logic [ID_W:0]         w_cand_sum [NUM_REQ];
    logic [ID_W-1:0]       w_cand     [NUM_REQ];
    logic                  w_sel_valid;
    logic [ID_W-1:0]       w_sel_idx;

    logic                  w_take;
    logic                  w_arvalid;
    logic                  w_ar_hs;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [ID_W-1:0]       w_head;
    logic                  w_pop;

    // Per-requester unpacking; w_cand[k] is the k-th requester in round-robin order from r_rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_req_addr[gi] = s_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_req_len[gi]  = s_arlen[gi*32 +: 32];
            assign w_cand_sum[gi] = {1'b0, r_rr_ptr} + (ID_W+1)'(gi);
            assign w_cand[gi]     = (w_cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                                  ? ID_W'(w_cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                                  : ID_W'(w_cand_sum[gi]);
            assign s_arready[gi]  = w_ar_hs && (r_grant == ID_W'(gi));
            assign s_rvalid[gi]   = m_rvalid && !w_fifo_empty && (w_head == ID_W'(gi));
        end
    endgenerate

    // Scan from the far end so the candidate closest to r_rr_ptr wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (s_arvalid[w_cand[k]]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_cand[k];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_take)    w_state_next = ISSUE;
            ISSUE:   if (m_arready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The full check uses the current count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        w_take    = 1'b0;
        w_arvalid = 1'b0;
        w_ar_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                w_take = w_sel_valid && !w_fifo_full;
            end
            ISSUE: begin
                w_arvalid = 1'b1;
                w_ar_hs   = m_arready;
            end
            default: begin
                w_take = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
        end else begin
            if (w_take) begin
                r_grant  <= w_sel_idx;
                r_araddr <= w_req_addr[w_sel_idx];
                r_arlen  <= w_req_len[w_sel_idx];
            end
            if (w_ar_hs) begin
                r_rr_ptr <= ID_W'(rr_next(32'(r_grant), NUM_REQ));
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rburst_ready <= 1'b0;
        end else begin
            r_rburst_ready <= 1'b1;
        end
    end

    output_drainer_q_fp32_output_mmap_m_axi_fifo #(
        .DATA_WIDTH (ID_W),
        .DEPTH      (NUM_OUTSTANDING)
    ) u_grant_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .i_push  (w_ar_hs),
        .i_data  (r_grant),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // R path is purely combinational: the FIFO head owns whatever beat is on the bus.
    assign m_rready       = !w_fifo_empty && s_rready[w_head];
    assign w_pop          = m_rvalid && m_rready && m_rlast[RLAST_REQ];
    assign s_rdata        = m_rdata;
    assign s_rlast        = {m_rlast[RLAST_BURST], m_rlast[RLAST_REQ]};

    assign m_arvalid      = w_arvalid;
    assign m_araddr       = r_araddr;
    assign m_arlen        = r_arlen;
    assign m_rburst_ready = r_rburst_ready;

endmodule

// File: tb/tb_blk_9ca83e.sv
// Self-checking bench for the m_axi read arbiter: table-driven grant sequences plus
// hand-written FIFO-full, ordering/backpressure and async-reset sequences.
module tb_blk_9ca83e;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [127:0] s_araddr;
    logic [63:0]  s_arlen;
    logic [1:0]   s_arvalid;
    logic [1:0]   s_arready;
    logic [511:0] s_rdata;
    logic [1:0]   s_rlast;
    logic [1:0]   s_rvalid;
    logic [1:0]   s_rready;
    logic [63:0]  m_araddr;
    logic [31:0]  m_arlen;
    logic         m_arvalid;
    logic         m_arready;
    logic [511:0] m_rdata;
    logic [1:0]   m_rlast;
    logic         m_rvalid;
    logic         m_rready;
    logic         m_rburst_ready;

    logic [63:0]  addr_tab [2];
    logic [31:0]  len_tab  [2];

    int n_checks = 0;
    int n_pass   = 0;

    int exp_owner [$];
    int exp_len   [$];

    typedef struct {
        logic [1:0] mask;
        int         exp_grant;
        int         stall;
    } ar_vec_t;

    ar_vec_t tab [8];

    assign s_araddr = {addr_tab[1], addr_tab[0]};
    assign s_arlen  = {len_tab[1], len_tab[0]};

    always #5 ACLK = ~ACLK;

    blk_9ca83e dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .s_araddr       (s_araddr),
        .s_arlen        (s_arlen),
        .s_arvalid      (s_arvalid),
        .s_arready      (s_arready),
        .s_rdata        (s_rdata),
        .s_rlast        (s_rlast),
        .s_rvalid       (s_rvalid),
        .s_rready       (s_rready),
        .m_araddr       (m_araddr),
        .m_arlen        (m_arlen),
        .m_arvalid      (m_arvalid),
        .m_arready      (m_arready),
        .m_rdata        (m_rdata),
        .m_rlast        (m_rlast),
        .m_rvalid       (m_rvalid),
        .m_rready       (m_rready),
        .m_rburst_ready (m_rburst_ready)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present a request mask, wait for the issue, optionally stall ARREADY, then handshake.
    task automatic ar_accept(input logic [1:0] mask, input int exp_g, input int stall, input bit chk_lat);
        int         waited = 0;
        logic [1:0] oh;
        oh = 2'b01 << exp_g;
        s_arvalid = mask;
        #1;
        while (!m_arvalid && waited < 20) begin
            @(negedge ACLK); #1;
            waited++;
        end
        if (!m_arvalid) begin
            chk("ar_timeout", 1'b0, 1'b1);
            s_arvalid = 2'b00;
            return;
        end
        if (chk_lat) chk("ar_latency", waited, 1);
        chk("m_araddr", m_araddr, addr_tab[exp_g]);
        chk("m_arlen", m_arlen, len_tab[exp_g]);
        for (int k = 0; k < stall; k++) begin
            chk("stall_arvalid", m_arvalid, 1'b1);
            chk("stall_araddr", m_araddr, addr_tab[exp_g]);
            chk("stall_arlen", m_arlen, len_tab[exp_g]);
            chk("stall_arready", s_arready, 2'b00);
            @(negedge ACLK); #1;
        end
        m_arready = 1'b1;
        #1;
        chk("s_arready_grant", s_arready, oh);
        exp_owner.push_back(exp_g);
        exp_len.push_back(int'(len_tab[exp_g]));
        $display("AR grant=%0d addr=%0h len=%0d", exp_g, m_araddr, m_arlen);
        @(negedge ACLK);
        m_arready = 1'b0;
        s_arvalid = 2'b00;
        #1;
        chk("s_arready_pulse", s_arready, 2'b00);
    endtask

    // Deliver all beats of the oldest outstanding request; stall the owner's RREADY on one beat.
    task automatic drain_one(input int stall_beat);
        int           owner;
        int           len;
        logic [1:0]   oh;
        logic [511:0] d;
        if (exp_owner.size() == 0) begin
            chk("sb_underflow", 1'b0, 1'b1);
            return;
        end
        owner = exp_owner.pop_front();
        len   = exp_len.pop_front();
        oh    = 2'b01 << owner;
        for (int b = 0; b < len; b++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
            m_rdata  = d;
            m_rvalid = 1'b1;
            m_rlast  = (b == len - 1) ? 2'b11 : 2'b00;
            s_rready = oh;
            if (b == stall_beat) begin
                s_rready = 2'b00;
                for (int k = 0; k < 2; k++) begin
                    #1;
                    chk("stall_rvalid", s_rvalid, oh);
                    chk("stall_mrready", m_rready, 1'b0);
                    chk("stall_rdata", s_rdata, d);
                    @(negedge ACLK);
                end
                s_rready = oh;
            end
            #1;
            chk("s_rvalid", s_rvalid, oh);
            chk("m_rready", m_rready, 1'b1);
            chk("s_rdata", s_rdata, d);
            chk("s_rlast", s_rlast, (b == len - 1) ? 2'b11 : 2'b00);
            $display("R beat owner=%0d idx=%0d/%0d", owner, b + 1, len);
            @(negedge ACLK);
        end
        m_rvalid = 1'b0;
        m_rlast  = 2'b00;
        s_rready = 2'b00;
    endtask

    task automatic chk_empty(input string name);
        m_rvalid = 1'b1;
        s_rready = 2'b11;
        #1;
        chk({name, "_rvalid"}, s_rvalid, 2'b00);
        chk({name, "_mrready"}, m_rready, 1'b0);
        m_rvalid = 1'b0;
        s_rready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{2'b11, 0, 0};
        tab[1] = '{2'b11, 1, 0};
        tab[2] = '{2'b11, 0, 0};
        tab[3] = '{2'b11, 1, 0};
        tab[4] = '{2'b01, 0, 0};
        tab[5] = '{2'b11, 1, 2};
        tab[6] = '{2'b10, 1, 0};
        tab[7] = '{2'b11, 0, 0};

        ARESETN   = 1'b0;
        s_arvalid = 2'b00;
        s_rready  = 2'b00;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rlast   = 2'b00;
        m_rvalid  = 1'b0;
        addr_tab[0] = 64'h1000;
        addr_tab[1] = 64'h2000;
        len_tab[0]  = 32'd4;
        len_tab[1]  = 32'd3;

        // Reset values
        repeat (3) @(negedge ACLK);
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        #1;
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_arready", s_arready, 2'b00);
        chk_empty("rst");
        chk("rst_rburst", m_rburst_ready, 1'b0);
        s_arvalid = 2'b00;
        m_arready = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        chk("rburst_pre_edge", m_rburst_ready, 1'b0);

        // Single request from requester 0
        ar_accept(2'b01, 0, 0, 1'b1);
        chk("rburst_ready", m_rburst_ready, 1'b1);
        drain_one(-1);
        chk_empty("single_done");

        // ARREADY backpressure on requester 1
        ar_accept(2'b10, 1, 5, 1'b1);
        drain_one(-1);
        chk_empty("bp_done");

        // Contention: alternating grants until the FIFO is full
        len_tab[0] = 32'd2;
        len_tab[1] = 32'd3;
        for (int i = 0; i < 4; i++) ar_accept(tab[i].mask, tab[i].exp_grant, tab[i].stall, 1'b0);

        // FIFO full: no fifth issue until a request_end beat pops
        s_arvalid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("full_no_arvalid", m_arvalid, 1'b0);
            chk("full_no_arready", s_arready, 2'b00);
            @(negedge ACLK);
        end
        drain_one(1);
        ar_accept(2'b11, 0, 0, 1'b0);
        while (exp_owner.size() > 0) drain_one(1);
        chk_empty("order_done");

        // Second table half: round-robin from a non-zero pointer with sparse masks
        for (int i = 4; i < 8; i++) ar_accept(tab[i].mask, tab[i].exp_grant, tab[i].stall, 1'b0);
        while (exp_owner.size() > 0) drain_one(0);
        chk_empty("tab2_done");

        // Async reset mid-ISSUE with two outstanding requests and rr_ptr=1
        ar_accept(2'b01, 0, 0, 1'b0);
        ar_accept(2'b01, 0, 0, 1'b0);
        s_arvalid = 2'b11;
        begin
            int waited = 0;
            #1;
            while (!m_arvalid && waited < 20) begin
                @(negedge ACLK); #1;
                waited++;
            end
        end
        chk("pre_rst_issue", m_arvalid, 1'b1);
        chk("pre_rst_addr", m_araddr, addr_tab[1]);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("arst_arvalid", m_arvalid, 1'b0);
        chk("arst_rburst", m_rburst_ready, 1'b0);
        chk_empty("arst");
        @(negedge ACLK);
        #1;
        chk("arst_edge_arvalid", m_arvalid, 1'b0);
        chk_empty("arst_edge");
        s_arvalid = 2'b00;
        ARESETN   = 1'b1;
        exp_owner.delete();
        exp_len.delete();
        ar_accept(2'b11, 0, 0, 1'b1);
        drain_one(-1);
        chk_empty("post_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
